code_entry_fsm: RTL and testbench
=================================

// Module: code_entry_fsm
// PURPOSE
// - Digit-code controller for the digital lock. Sits directly downstream of the per-key button debouncers.
// - Consumes 4 debounced key levels and edge-detects each one into a 2-bit digit.
// - Collects a CODE_LEN-digit sequence, compares it against a stored code and drives the lock/unlock status.
// - Supports changing the code while unlocked, an inter-key timeout and an optional failed-attempt lockout.
// PARAMETERS
// - CODE_LEN       4              digits per code (1..8)
// - DEFAULT_CODE   8'b00_01_10_11 reset code, first digit in MS bits (2*CODE_LEN bits wide)
// - TIMEOUT_CYCLES 50_000_000     idle clk_in cycles in ENTRY/SET before abort (1 s at 50 MHz)
// - MAX_FAILS      3              consecutive failed attempts that trigger lockout (LOCKOUT_EN only)
// - LOCKOUT_CYCLES 500_000_000    lockout duration in clk_in cycles (LOCKOUT_EN only)
// PORTS
// - clk_in         in   1           system clock, 50 MHz
// - rst_n_in       in   1           asynchronous, active-low reset
// - key_in         in   4           debounced key levels; key i = digit i
// - lock_in        in   1           debounced "lock" button (level)
// - set_in         in   1           debounced "set code" button (level)
// - unlocked_out   out  1           1 while in UNLOCKED or SET
// - error_out      out  1           1-cycle pulse on a failed comparison
// - digit_cnt_out  out  4           digits captured in the current ENTRY/SET sequence
// - lockout_out    out  1           1 while in LOCKOUT (constant 0 without LOCKOUT_EN)
// BEHAVIOUR
// - Reset: state=IDLE, stored code=DEFAULT_CODE, digit count=0, fail count=0, timers=0.
//   All outputs are 0 during reset. Edge-detect registers are cleared to 0, so a key already held at reset release registers a press.
// - Edge detect: prev <= key_in each cycle; press = key_in & ~prev.
//   - Exactly one press bit set: valid digit = its index.
//   - More than one press bit set in the same cycle: the digit is still counted, but the sequence is marked invalid and fails at CHECK.
//   - lock_in and set_in are edge-detected the same way.
// - States: IDLE, ENTRY, CHECK, UNLOCKED, SET, LOCKOUT.
// - IDLE: any press -> ENTRY, with that press captured as the first digit (digit_cnt=1).
// - ENTRY:
//   - Each press shifts the digit in (MS-first) and resets the timeout timer.
//   - When digit_cnt reaches CODE_LEN -> CHECK.
//   - TIMEOUT_CYCLES cycles without a press -> IDLE; digits cleared; not counted as a failure.
// - CHECK (1 cycle):
//   - Match and valid: -> UNLOCKED; fail count cleared.
//   - Otherwise: error_out pulses this cycle; fail count +1 (saturating); -> IDLE.
//   - Latency: unlocked_out is high 2 clk_in edges after the edge at which the final key is first sampled high.
// - UNLOCKED:
//   - lock_in press -> IDLE.
//   - set_in press -> SET (digit_cnt=0).
//   - Key presses are ignored.
//   - lock_in and set_in pressed in the same cycle: lock_in wins.
// - SET:
//   - Presses shift into a shadow register.
//   - At CODE_LEN digits: if valid, the stored code is updated; if invalid, it is kept unchanged. Then -> UNLOCKED.
//   - Timeout or lock_in press: shadow discarded, stored code unchanged. Timeout -> UNLOCKED; lock_in -> IDLE.
// - Timers saturate and never wrap. digit_cnt never exceeds CODE_LEN.
// - Reset mid-sequence aborts everything; the stored code reverts to DEFAULT_CODE (the code is not persistent).
// CONFIGURATION
// - LOCKOUT_EN defined:
//   - In CHECK, a failure that brings the fail count to MAX_FAILS -> LOCKOUT; that failure still pulses error_out.
//   - LOCKOUT: lockout_out=1, all presses ignored; after LOCKOUT_CYCLES cycles -> IDLE with fail count cleared.
// - LOCKOUT_EN undefined: no LOCKOUT state, fail counter or lockout timer; lockout_out tied to 0. MAX_FAILS and LOCKOUT_CYCLES are unused.
// TESTING (CODE_LEN=4, DEFAULT_CODE=0,1,2,3, TIMEOUT_CYCLES=100, LOCKOUT_CYCLES=200)
// - Reset then press keys 0,1,2,3 (10-cycle pulses) -> unlocked_out=1 two edges after key 3 is sampled; error_out never high.
// - Press 0,1,2,2 -> error_out 1-cycle pulse; state IDLE; unlocked_out=0; digit_cnt_out=0.
// - Press 0,1 then idle 100 cycles -> digit_cnt_out returns to 0, no error_out; then 0,1,2,3 -> unlocked.
// - Unlocked; set_in; press 3,3,1,0; lock_in; then 0,1,2,3 -> error_out; then 3,3,1,0 -> unlocked.
// - Keys 1 and 2 rise in the same cycle as the 2nd digit -> fails at CHECK even if the other digits match.
// - LOCKOUT_EN: 3 wrong codes -> lockout_out=1 for 200 cycles with correct code ignored; afterwards 0,1,2,3 -> unlocked.

Source files
------------

// File: rtl/code_entry_fsm.sv
// code_entry_fsm - digit-code controller for the digital lock.
// Edge-detects four debounced key levels into 2-bit digits, collects a
// CODE_LEN-digit sequence, compares it with the stored code and drives the
// lock status. Supports code change while unlocked and an inter-key timeout.
// Optional feature: define LOCKOUT_EN to add the failed-attempt lockout
// (LOCKOUT state, fail counter, lockout timer); otherwise lockout_out is 0.
// Key, lock and set edges are registered once before the FSM, so the FSM
// acts one cycle after a level is first sampled high.
module code_entry_fsm #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE   = 8'b00_01_10_11,
    parameter int                    TIMEOUT_CYCLES = 50_000_000,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 500_000_000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [3:0] key_in,
    input  logic       lock_in,
    input  logic       set_in,
    output logic       unlocked_out,
    output logic       error_out,
    output logic [3:0] digit_cnt_out,
    output logic       lockout_out
);

    localparam int CW = 2 * CODE_LEN;

`ifdef LOCKOUT_EN
    localparam bit LOCKOUT_ON = 1'b1;
`else
    localparam bit LOCKOUT_ON = 1'b0;
`endif

    // One shared timer serves the inter-key timeout and the lockout period,
    // so it is sized for the longer of the two when lockout is built in.
    localparam int TIMER_MAX = (LOCKOUT_ON && (LOCKOUT_CYCLES > TIMEOUT_CYCLES)) ?
                               LOCKOUT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(TIMER_MAX + 1);
    localparam logic [TW-1:0] TIMER_SAT    = TW'(TIMER_MAX);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    CODE_LEN_CNT = 4'(CODE_LEN);

`ifdef LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] FAILS_LIMIT  = FW'(MAX_FAILS);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
`endif

    // Reject configurations the counters cannot represent.
    if ((CODE_LEN < 1) || (CODE_LEN > 8) || (TIMEOUT_CYCLES < 1) ||
        (MAX_FAILS < 1) || (LOCKOUT_CYCLES < 1)) begin : g_bad_config
        $error("code_entry_fsm: parameter out of range");
    end

`ifdef LOCKOUT_EN
    typedef enum logic [2:0] {
        IDLE, ENTRY, CHECK, UNLOCKED, SET, LOCKOUT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ENTRY, CHECK, UNLOCKED, SET
    } state_t;
`endif

    // Edge-detect state
    logic [3:0] key_prev_reg;
    logic [3:0] key_press_reg;
    logic [3:0] key_press_next;
    logic       lock_prev_reg;
    logic       lock_press_reg;
    logic       set_prev_reg;
    logic       set_press_reg;

    // FSM and datapath state
    state_t        state_reg,       state_next;
    logic [CW-1:0] code_buf_reg,    code_buf_next;
    logic          seq_ok_reg,      seq_ok_next;
    logic [3:0]    digit_cnt_reg,   digit_cnt_next;
    logic [TW-1:0] timer_reg,       timer_next;
    logic [CW-1:0] stored_code_reg, stored_code_next;
`ifdef LOCKOUT_EN
    logic [FW-1:0] fail_cnt_reg,    fail_cnt_next;
    logic [FW-1:0] fail_inc;
`endif

    // Decoded helpers
    logic          press_any;
    logic          press_multi;
    logic [1:0]    digit;
    logic [CW-1:0] shifted_code;
    logic [3:0]    cnt_inc;
    logic [TW-1:0] timer_inc;
    logic          code_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_edge
            assign key_press_next[gi] = key_in[gi] & ~key_prev_reg[gi];
        end
    endgenerate

    // Register input levels and their rising edges; cleared to 0 so a key
    // held through reset release still counts as a press.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            key_prev_reg   <= 4'd0;
            key_press_reg  <= 4'd0;
            lock_prev_reg  <= 1'b0;
            lock_press_reg <= 1'b0;
            set_prev_reg   <= 1'b0;
            set_press_reg  <= 1'b0;
        end else begin
            key_prev_reg   <= key_in;
            key_press_reg  <= key_press_next;
            lock_prev_reg  <= lock_in;
            lock_press_reg <= lock_in & ~lock_prev_reg;
            set_prev_reg   <= set_in;
            set_press_reg  <= set_in & ~set_prev_reg;
        end
    end

    // Decode the registered key edges into a digit and derived values.
    always_comb begin
        press_any   = |key_press_reg;
        press_multi = (key_press_reg & (key_press_reg - 4'd1)) != 4'd0;
        digit       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (key_press_reg[i]) begin
                digit = 2'(i);
            end
        end
        shifted_code = (code_buf_reg << 2) | CW'(digit);
        cnt_inc      = digit_cnt_reg + 4'd1;
        timer_inc    = (timer_reg == TIMER_SAT) ? timer_reg : timer_reg + TW'(1);
        code_ok      = seq_ok_reg && (code_buf_reg == stored_code_reg);
`ifdef LOCKOUT_EN
        fail_inc     = (fail_cnt_reg == FAILS_LIMIT) ? fail_cnt_reg : fail_cnt_reg + FW'(1);
`endif
    end

    // Next-state and datapath updates. The entry buffer doubles as the
    // shadow register in SET since the two are never live together.
    always_comb begin
        state_next       = state_reg;
        code_buf_next    = code_buf_reg;
        seq_ok_next      = seq_ok_reg;
        digit_cnt_next   = digit_cnt_reg;
        timer_next       = timer_reg;
        stored_code_next = stored_code_reg;
`ifdef LOCKOUT_EN
        fail_cnt_next    = fail_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (press_any) begin
                    code_buf_next  = shifted_code;
                    seq_ok_next    = ~press_multi;
                    digit_cnt_next = 4'd1;
                    state_next     = (CODE_LEN_CNT == 4'd1) ? CHECK : ENTRY;
                end
            end

            ENTRY: begin
                if (press_any) begin
                    code_buf_next  = shifted_code;
                    seq_ok_next    = seq_ok_reg & ~press_multi;
                    digit_cnt_next = cnt_inc;
                    timer_next     = '0;
                    if (cnt_inc == CODE_LEN_CNT) begin
                        state_next = CHECK;
                    end
                end else if (timer_reg == TIMEOUT_LAST) begin
                    // Abandoned entry: silent abort, not a failed attempt.
                    state_next     = IDLE;
                    code_buf_next  = '0;
                    digit_cnt_next = 4'd0;
                    timer_next     = '0;
                end else begin
                    timer_next = timer_inc;
                end
            end

            CHECK: begin
                code_buf_next  = '0;
                digit_cnt_next = 4'd0;
                seq_ok_next    = 1'b1;
                timer_next     = '0;
                if (code_ok) begin
                    state_next = UNLOCKED;
`ifdef LOCKOUT_EN
                    fail_cnt_next = '0;
`endif
                end else begin
`ifdef LOCKOUT_EN
                    fail_cnt_next = fail_inc;
                    state_next    = (fail_inc == FAILS_LIMIT) ? LOCKOUT : IDLE;
`else
                    state_next    = IDLE;
`endif
                end
            end

            UNLOCKED: begin
                timer_next = '0;
                if (lock_press_reg) begin
                    state_next = IDLE;
                end else if (set_press_reg) begin
                    state_next     = SET;
                    code_buf_next  = '0;
                    seq_ok_next    = 1'b1;
                    digit_cnt_next = 4'd0;
                end
            end

            SET: begin
                if (lock_press_reg) begin
                    state_next     = IDLE;
                    code_buf_next  = '0;
                    digit_cnt_next = 4'd0;
                    timer_next     = '0;
                end else if (press_any) begin
                    code_buf_next  = shifted_code;
                    seq_ok_next    = seq_ok_reg & ~press_multi;
                    digit_cnt_next = cnt_inc;
                    timer_next     = '0;
                    if (cnt_inc == CODE_LEN_CNT) begin
                        // Only a clean sequence replaces the stored code.
                        if (seq_ok_reg && !press_multi) begin
                            stored_code_next = shifted_code;
                        end
                        state_next     = UNLOCKED;
                        code_buf_next  = '0;
                        digit_cnt_next = 4'd0;
                    end
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next     = UNLOCKED;
                    code_buf_next  = '0;
                    digit_cnt_next = 4'd0;
                    timer_next     = '0;
                end else begin
                    timer_next = timer_inc;
                end
            end

`ifdef LOCKOUT_EN
            LOCKOUT: begin
                if (timer_reg == LOCKOUT_LAST) begin
                    state_next    = IDLE;
                    fail_cnt_next = '0;
                    timer_next    = '0;
                end else begin
                    timer_next = timer_inc;
                end
            end
`endif

            default: begin
                state_next     = IDLE;
                code_buf_next  = '0;
                digit_cnt_next = 4'd0;
                timer_next     = '0;
            end
        endcase
    end

    // State and datapath registers; the stored code is not persistent.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg       <= IDLE;
            code_buf_reg    <= '0;
            seq_ok_reg      <= 1'b1;
            digit_cnt_reg   <= 4'd0;
            timer_reg       <= '0;
            stored_code_reg <= DEFAULT_CODE;
`ifdef LOCKOUT_EN
            fail_cnt_reg    <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            code_buf_reg    <= code_buf_next;
            seq_ok_reg      <= seq_ok_next;
            digit_cnt_reg   <= digit_cnt_next;
            timer_reg       <= timer_next;
            stored_code_reg <= stored_code_next;
`ifdef LOCKOUT_EN
            fail_cnt_reg    <= fail_cnt_next;
`endif
        end
    end

    assign unlocked_out  = (state_reg == UNLOCKED) || (state_reg == SET);
    assign error_out     = (state_reg == CHECK) && !code_ok;
    assign digit_cnt_out = digit_cnt_reg;
`ifdef LOCKOUT_EN
    assign lockout_out   = (state_reg == LOCKOUT);
`else
    assign lockout_out   = 1'b0;
`endif

endmodule

// File: tb/tb_code_entry_fsm.sv
// Directed bench for code_entry_fsm (CODE_LEN=4, code 0,1,2,3,
// TIMEOUT_CYCLES=100, LOCKOUT_CYCLES=200). Inputs change and outputs are
// sampled on the falling edge. Lockout checks follow LOCKOUT_EN.
module tb_code_entry_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'd0;
    logic       lock_btn = 1'b0;
    logic       set_btn = 1'b0;
    logic       unlocked;
    logic       error_flag;
    logic [3:0] digit_cnt;
    logic       lockout;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;

    code_entry_fsm #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (8'b00_01_10_11),
        .TIMEOUT_CYCLES (100),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (200)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .key_in        (key),
        .lock_in       (lock_btn),
        .set_in        (set_btn),
        .unlocked_out  (unlocked),
        .error_out     (error_flag),
        .digit_cnt_out (digit_cnt),
        .lockout_out   (lockout)
    );

    always #5 clk = ~clk;

    // Count cycles with error_out high (one per cycle).
    always @(negedge clk) begin
        if (error_flag === 1'b1) err_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press_key(input int k);
        key[k] = 1'b1;
        repeat (10) @(negedge clk);
        key[k] = 1'b0;
        repeat (2) @(negedge clk);
        $display("key %0d: digit_cnt=%0d unlocked=%0b lockout=%0b", k, digit_cnt, unlocked, lockout);
    endtask

    task automatic press_code(input int a, input int b, input int c, input int d);
        press_key(a);
        press_key(b);
        press_key(c);
        press_key(d);
    endtask

    task automatic press_lock();
        lock_btn = 1'b1;
        repeat (10) @(negedge clk);
        lock_btn = 1'b0;
        repeat (2) @(negedge clk);
        $display("lock: unlocked=%0b", unlocked);
    endtask

    task automatic press_set();
        set_btn = 1'b1;
        repeat (10) @(negedge clk);
        set_btn = 1'b0;
        repeat (2) @(negedge clk);
        $display("set: unlocked=%0b digit_cnt=%0d", unlocked, digit_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key = 4'd0;
        lock_btn = 1'b0;
        set_btn = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b expected 0", unlocked); end
        checks++; if (error_flag !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error_flag); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout: got %b expected 0", lockout); end
        // Key held through reset release must count as a press.
        key[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (digit_cnt !== 4'd1) begin errors++; $display("FAIL held_key_at_release: got %0d expected 1", digit_cnt); end
        key[0] = 1'b0;
        do_reset();
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_clears_cnt: got %0d expected 0", digit_cnt); end
    endtask

    task automatic test_unlock_latency();
        int err0;
        do_reset();
        err0 = err_pulses;
        press_key(0);
        press_key(1);
        press_key(2);
        checks++; if (digit_cnt !== 4'd3) begin errors++; $display("FAIL cnt_before_last: got %0d expected 3", digit_cnt); end
        key[3] = 1'b1;
        @(negedge clk);
        checks++; if (unlocked !== 1'b0 || digit_cnt !== 4'd3) begin errors++; $display("FAIL lat_edge0: got unlocked=%b cnt=%0d expected 0/3", unlocked, digit_cnt); end
        @(negedge clk);
        checks++; if (unlocked !== 1'b0 || digit_cnt !== 4'd4) begin errors++; $display("FAIL lat_edge1: got unlocked=%b cnt=%0d expected 0/4", unlocked, digit_cnt); end
        @(negedge clk);
        checks++; if (unlocked !== 1'b1 || digit_cnt !== 4'd0) begin errors++; $display("FAIL lat_edge2: got unlocked=%b cnt=%0d expected 1/0", unlocked, digit_cnt); end
        repeat (7) @(negedge clk);
        key[3] = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (err_pulses - err0 !== 0) begin errors++; $display("FAIL no_error_on_match: got %0d pulses expected 0", err_pulses - err0); end
        press_lock();
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL relock: got %b expected 0", unlocked); end
    endtask

    task automatic test_wrong_code();
        int err0;
        err0 = err_pulses;
        press_key(0);
        press_key(1);
        press_key(2);
        key[2] = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (error_flag !== 1'b1 || digit_cnt !== 4'd4) begin errors++; $display("FAIL err_pulse_high: got err=%b cnt=%0d expected 1/4", error_flag, digit_cnt); end
        @(negedge clk);
        checks++; if (error_flag !== 1'b0 || unlocked !== 1'b0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL err_after: got err=%b unl=%b cnt=%0d expected 0/0/0", error_flag, unlocked, digit_cnt); end
        repeat (7) @(negedge clk);
        key[2] = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (err_pulses - err0 !== 1) begin errors++; $display("FAIL err_pulse_width: got %0d cycles expected 1", err_pulses - err0); end
    endtask

    task automatic test_timeout();
        int err0;
        err0 = err_pulses;
        press_key(0);
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
        key[1] = 1'b0;
        repeat (91) @(negedge clk);
        checks++; if (digit_cnt !== 4'd2) begin errors++; $display("FAIL timeout_not_yet: got %0d expected 2", digit_cnt); end
        @(negedge clk);
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL timeout_clears: got %0d expected 0", digit_cnt); end
        checks++; if (err_pulses - err0 !== 0) begin errors++; $display("FAIL timeout_no_error: got %0d expected 0", err_pulses - err0); end
        press_code(0, 1, 2, 3);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL unlock_after_timeout: got %b expected 1", unlocked); end
        press_lock();
    endtask

    task automatic test_change_code();
        int err0;
        press_code(0, 1, 2, 3);
        press_set();
        checks++; if (unlocked !== 1'b1 || digit_cnt !== 4'd0) begin errors++; $display("FAIL enter_set: got unl=%b cnt=%0d expected 1/0", unlocked, digit_cnt); end
        press_key(3);
        press_key(3);
        checks++; if (digit_cnt !== 4'd2) begin errors++; $display("FAIL set_progress: got %0d expected 2", digit_cnt); end
        press_key(1);
        press_key(0);
        checks++; if (unlocked !== 1'b1 || digit_cnt !== 4'd0) begin errors++; $display("FAIL set_done: got unl=%b cnt=%0d expected 1/0", unlocked, digit_cnt); end
        press_lock();
        err0 = err_pulses;
        press_code(0, 1, 2, 3);
        checks++; if (err_pulses - err0 !== 1 || unlocked !== 1'b0) begin errors++; $display("FAIL old_code_rejected: got pulses=%0d unl=%b expected 1/0", err_pulses - err0, unlocked); end
        press_code(3, 3, 1, 0);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL new_code_accepted: got %b expected 1", unlocked); end
    endtask

    task automatic test_reset_reverts_code();
        int err0;
        // Entered while unlocked with code 3,3,1,0; reset is asynchronous.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL async_reset: got %b expected 0", unlocked); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        err0 = err_pulses;
        press_code(3, 3, 1, 0);
        checks++; if (err_pulses - err0 !== 1 || unlocked !== 1'b0) begin errors++; $display("FAIL changed_code_lost: got pulses=%0d unl=%b expected 1/0", err_pulses - err0, unlocked); end
        press_code(0, 1, 2, 3);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL default_restored: got %b expected 1", unlocked); end
        press_lock();
    endtask

    task automatic test_set_abort();
        do_reset();
        press_code(0, 1, 2, 3);
        press_key(0);
        checks++; if (digit_cnt !== 4'd0 || unlocked !== 1'b1) begin errors++; $display("FAIL keys_ignored_unlocked: got cnt=%0d unl=%b expected 0/1", digit_cnt, unlocked); end
        press_set();
        press_key(2);
        press_key(2);
        press_lock();
        checks++; if (unlocked !== 1'b0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL set_lock_abort: got unl=%b cnt=%0d expected 0/0", unlocked, digit_cnt); end
        press_code(0, 1, 2, 3);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL code_kept_after_abort: got %b expected 1", unlocked); end
        press_set();
        press_key(1);
        repeat (110) @(negedge clk);
        checks++; if (unlocked !== 1'b1 || digit_cnt !== 4'd0) begin errors++; $display("FAIL set_timeout: got unl=%b cnt=%0d expected 1/0", unlocked, digit_cnt); end
        lock_btn = 1'b1;
        set_btn = 1'b1;
        repeat (10) @(negedge clk);
        lock_btn = 1'b0;
        set_btn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL lock_beats_set: got %b expected 0", unlocked); end
        press_code(0, 1, 2, 3);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL code_kept_after_timeout: got %b expected 1", unlocked); end
        press_lock();
    endtask

    task automatic test_multi_press();
        int err0;
        err0 = err_pulses;
        press_key(0);
        key = 4'b0110;
        repeat (10) @(negedge clk);
        key = 4'b0000;
        repeat (2) @(negedge clk);
        checks++; if (digit_cnt !== 4'd2) begin errors++; $display("FAIL multi_counted: got %0d expected 2", digit_cnt); end
        press_key(2);
        press_key(3);
        checks++; if (err_pulses - err0 !== 1 || unlocked !== 1'b0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL multi_fails: got pulses=%0d unl=%b cnt=%0d expected 1/0/0", err_pulses - err0, unlocked, digit_cnt); end
        press_code(0, 1, 2, 3);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL unlock_after_multi: got %b expected 1", unlocked); end
        press_lock();
    endtask

    task automatic test_back_to_back();
        int err0;
        do_reset();
        err0 = err_pulses;
        press_code(1, 1, 1, 1);
        press_code(2, 2, 2, 2);
        press_key(1);
        press_key(1);
        press_key(1);
        press_key(3);
        checks++; if (err_pulses - err0 !== 3) begin errors++; $display("FAIL three_failures: got %0d pulses expected 3", err_pulses - err0); end
`ifdef LOCKOUT_EN
        checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL lockout_entered: got %b expected 1", lockout); end
        press_code(0, 1, 2, 3);
        checks++; if (unlocked !== 1'b0 || lockout !== 1'b1 || digit_cnt !== 4'd0) begin errors++; $display("FAIL lockout_ignores: got unl=%b lo=%b cnt=%0d expected 0/1/0", unlocked, lockout, digit_cnt); end
        repeat (142) @(negedge clk);
        checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL lockout_last_cycle: got %b expected 1", lockout); end
        @(negedge clk);
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL lockout_released: got %b expected 0", lockout); end
`else
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL lockout_tied_low: got %b expected 0", lockout); end
`endif
        press_code(0, 1, 2, 3);
        checks++; if (unlocked !== 1'b1 || lockout !== 1'b0) begin errors++; $display("FAIL unlock_after_fails: got unl=%b lo=%b expected 1/0", unlocked, lockout); end
        press_lock();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_unlock_latency();
        test_wrong_code();
        test_timeout();
        test_change_code();
        test_reset_reverts_code();
        test_set_abort();
        test_multi_press();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
